bit_xor_scheduler: RTL and testbench

// Shares one combinational 1-bit XOR unit (ports a_in/b_in -> y_out) between two

---
 rtl/bit_xor_scheduler.sv | 131 +++++++++++++
 tb/tb_bit_xor_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_xor_scheduler.sv
// Round-robin scheduler that shares one external 1-bit XOR between two requesters.
// Operands are streamed LSB-first through the XOR, one bit per clock.
module bit_xor_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req0_valid_in,
  output logic             req0_ready_out,
  input  logic [WIDTH-1:0] req0_a_in,
  input  logic [WIDTH-1:0] req0_b_in,
  input  logic             req1_valid_in,
  output logic             req1_ready_out,
  input  logic [WIDTH-1:0] req1_a_in,
  input  logic [WIDTH-1:0] req1_b_in,
  output logic             xor_a_out,
  output logic             xor_b_out,
  input  logic             xor_y_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic             rsp_id_out,
  output logic [WIDTH-1:0] rsp_y_out,
  output logic             busy_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] aOp_q, aOp_d;
  logic [WIDTH-1:0] bOp_q, bOp_d;
  logic [WIDTH-1:0] yRes_q, yRes_d;
  logic             id_q, id_d;
  logic             lastGrant_q, lastGrant_d;

  logic             anyValid;
  logic             grantId;
  logic             inIdle;
  logic             inShift;

  assign inIdle  = (state_q == IDLE);
  assign inShift = (state_q == SHIFT);

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    anyValid = req0_valid_in | req1_valid_in;
    grantId  = 1'b0;
    if (req0_valid_in && req1_valid_in) begin
      grantId = ~lastGrant_q;
    end else begin
      grantId = req1_valid_in;
    end
  end

  assign req0_ready_out = inIdle & anyValid & ~grantId;
  assign req1_ready_out = inIdle & anyValid & grantId;

  assign xor_a_out = inShift ? aOp_q[cnt_q] : 1'b0;
  assign xor_b_out = inShift ? bOp_q[cnt_q] : 1'b0;

  assign rsp_valid_out = (state_q == RESP);
  assign rsp_id_out    = id_q;
  assign rsp_y_out     = yRes_q;
  assign busy_out      = ~inIdle;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aOp_d       = aOp_q;
    bOp_d       = bOp_q;
    yRes_d      = yRes_q;
    id_d        = id_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      IDLE: begin
        if (anyValid) begin
          aOp_d       = grantId ? req1_a_in : req0_a_in;
          bOp_d       = grantId ? req1_b_in : req0_b_in;
          id_d        = grantId;
          lastGrant_d = grantId;
          cnt_d       = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        yRes_d[cnt_q] = xor_y_in;
        if (cnt_q == LAST_BIT) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      aOp_q       <= '0;
      bOp_q       <= '0;
      yRes_q      <= '0;
      id_q        <= 1'b0;
      lastGrant_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aOp_q       <= aOp_d;
      bOp_q       <= bOp_d;
      yRes_q      <= yRes_d;
      id_q        <= id_d;
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: tb/tb_bit_xor_scheduler.sv
// Randomised scoreboard bench for bit_xor_scheduler, with a timing-level reference
// model for handshakes and XOR lane traffic, plus a small WIDTH=2 instance.
module tb_bit_xor_scheduler;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         v0, v1, r0, r1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         xa, xb, xy;
  logic         rv, rr, rid, busy;
  logic [W-1:0] ry;

  logic         w2v, w2r, w2xa, w2xb, w2xy, w2rv, w2rr, w2id, w2busy, w2r1;
  logic [1:0]   w2a, w2b, w2y;

  // The shared XOR units themselves live in the bench.
  assign xy   = xa ^ xb;
  assign w2xy = w2xa ^ w2xb;

  bit_xor_scheduler #(.WIDTH(W)) dut (
    .clk_in(clk), .rst_in(rst),
    .req0_valid_in(v0), .req0_ready_out(r0), .req0_a_in(a0), .req0_b_in(b0),
    .req1_valid_in(v1), .req1_ready_out(r1), .req1_a_in(a1), .req1_b_in(b1),
    .xor_a_out(xa), .xor_b_out(xb), .xor_y_in(xy),
    .rsp_valid_out(rv), .rsp_ready_in(rr), .rsp_id_out(rid), .rsp_y_out(ry),
    .busy_out(busy)
  );

  bit_xor_scheduler #(.WIDTH(2)) dut2 (
    .clk_in(clk), .rst_in(rst),
    .req0_valid_in(w2v), .req0_ready_out(w2r), .req0_a_in(w2a), .req0_b_in(w2b),
    .req1_valid_in(1'b0), .req1_ready_out(w2r1), .req1_a_in(2'b00), .req1_b_in(2'b00),
    .xor_a_out(w2xa), .xor_b_out(w2xb), .xor_y_in(w2xy),
    .rsp_valid_out(w2rv), .rsp_ready_in(w2rr), .rsp_id_out(w2id), .rsp_y_out(w2y),
    .busy_out(w2busy)
  );

  typedef struct {
    bit           id;
    logic [W-1:0] y;
  } rsp_t;

  rsp_t expQ[$];
  bit   dutGrants[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acceptCyc = -1;
  bit   lastGrant = 1'b1;
  logic [W-1:0] mA, mB;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: the transaction accepted at cycle n streams bit k-1 in cycle n+k
  // (k=1..W) and offers its result from cycle n+W+1 until the consumer takes it.
  always @(negedge clk) begin : model
    int k;
    bit idle, e0, e1, g;
    logic eA, eB;
    cyc++;
    if (rst) begin
      acceptCyc = -1;
      lastGrant = 1'b1;
      expQ.delete();
    end else begin
      idle = (acceptCyc < 0);
      k    = cyc - acceptCyc;
      g    = 1'b0;
      e0   = 1'b0;
      e1   = 1'b0;
      if (idle && (v0 || v1)) begin
        g  = (v0 && v1) ? !lastGrant : v1;
        e0 = !g;
        e1 = g;
      end
      eA = 1'b0;
      eB = 1'b0;
      if (!idle && k >= 1 && k <= W) begin
        eA = mA[k-1];
        eB = mB[k-1];
      end
      if (r0 || r1) dutGrants.push_back(r1);
      checkOutput("req0_ready", r0, e0);
      checkOutput("req1_ready", r1, e1);
      checkOutput("busy", busy, !idle);
      checkOutput("rsp_valid", rv, !idle && k > W);
      checkOutput("xor_a", xa, eA);
      checkOutput("xor_b", xb, eB);
      if (e0 || e1) begin
        acceptCyc = cyc;
        lastGrant = g;
        mA = g ? a1 : a0;
        mB = g ? b1 : b0;
        expQ.push_back('{id: g, y: mA ^ mB});
      end else if (!idle && k > W && rr) begin
        acceptCyc = -1;
      end
    end
  end

  // Response monitor: every presented result must match the oldest outstanding one.
  always @(negedge clk) begin : monitor
    if (!rst && rv) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_rsp: got id=%0d y=%0h expected no response", rid, ry);
      end else begin
        checkOutput("rsp_id", rid, expQ[0].id);
        checkOutput("rsp_y", ry, expQ[0].y);
        if (rr) void'(expQ.pop_front());
      end
    end
  end

  // One cycle of stimulus: requesters hold valid until accepted, then re-arm with probability pN.
  task automatic applyStimulus(input int p0, input int p1, input int pRdy);
    bit acc0, acc1;
    @(negedge clk);
    acc0 = r0 && !rst;
    acc1 = r1 && !rst;
    @(posedge clk);
    #1;
    if (acc0) begin v0 = 1'b0; a0 = $urandom; b0 = $urandom; end
    if (acc1) begin v1 = 1'b0; a1 = $urandom; b1 = $urandom; end
    if (!v0 && int'($urandom_range(99)) < p0) begin v0 = 1'b1; a0 = $urandom; b0 = $urandom; end
    if (!v1 && int'($urandom_range(99)) < p1) begin v1 = 1'b1; a1 = $urandom; b1 = $urandom; end
    rr = (int'($urandom_range(99)) < pRdy);
  endtask

  task automatic drain();
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (2 * (W + 2)) applyStimulus(0, 0, 100);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic runSingle(input logic [W-1:0] a, input logic [W-1:0] b);
    v0 = 1'b1;
    a0 = a;
    b0 = b;
    rr = 1'b1;
    repeat (W + 4) applyStimulus(0, 0, 100);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    w2v = 1'b0; w2a = 2'b00; w2b = 2'b00; w2rr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_rsp_y", ry, 0);
    checkOutput("reset_rsp_id", rid, 0);
    checkOutput("reset_w2_rsp_y", w2y, 0);
    checkOutput("reset_w2_busy", w2busy, 0);
    @(posedge clk);
    #1;

    runSingle(8'hA5, 8'h0F);
    runSingle(8'hFF, 8'hFF);
    runSingle(8'h00, 8'hFF);

    // Fairness from reset with both requesters permanently valid.
    doReset();
    dutGrants.delete();
    v0 = 1'b1; a0 = $urandom; b0 = $urandom;
    v1 = 1'b1; a1 = $urandom; b1 = $urandom;
    rr = 1'b1;
    repeat (4 * (W + 2) + 3) applyStimulus(100, 100, 100);
    if (dutGrants.size() < 4) begin
      total++;
      bad++;
      $display("[TB] FAIL grant_count: got %0d grants expected at least 4", dutGrants.size());
    end else begin
      checkOutput("grant0", dutGrants[0], 0);
      checkOutput("grant1", dutGrants[1], 1);
      checkOutput("grant2", dutGrants[2], 0);
      checkOutput("grant3", dutGrants[3], 1);
    end
    drain();

    // Back-pressure in RESP with a competing request waiting.
    v0 = 1'b1; a0 = $urandom; b0 = $urandom;
    rr = 1'b0;
    applyStimulus(0, 0, 0);
    v1 = 1'b1; a1 = $urandom; b1 = $urandom;
    repeat (W + 6) applyStimulus(0, 100, 0);
    rr = 1'b1;
    applyStimulus(0, 100, 100);
    @(negedge clk);
    checkOutput("b2b_accept", r1, 1);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    drain();

    // Reset while the bit counter sits at 3.
    v0 = 1'b1; a0 = $urandom; b0 = $urandom;
    rr = 1'b1;
    applyStimulus(0, 0, 100);
    repeat (3) applyStimulus(0, 0, 100);
    rst = 1'b1;
    applyStimulus(0, 0, 100);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_rsp_valid", rv, 0);
    @(posedge clk);
    #1;
    runSingle($urandom, $urandom);

    // Random traffic.
    repeat (400) applyStimulus(40, 40, 60);
    drain();

    // WIDTH=2 instance: 01 ^ 11 = 10.
    w2v = 1'b1; w2a = 2'b01; w2b = 2'b11; w2rr = 1'b1;
    @(negedge clk);
    checkOutput("w2_ready", w2r, 1);
    @(posedge clk);
    #1;
    w2v = 1'b0; w2a = 2'b00; w2b = 2'b00;
    @(negedge clk);
    checkOutput("w2_xor_a_bit0", w2xa, 1);
    checkOutput("w2_xor_b_bit0", w2xb, 1);
    checkOutput("w2_rsp_valid_shift", w2rv, 0);
    @(negedge clk);
    checkOutput("w2_xor_a_bit1", w2xa, 0);
    checkOutput("w2_xor_b_bit1", w2xb, 1);
    @(negedge clk);
    checkOutput("w2_rsp_valid", w2rv, 1);
    checkOutput("w2_rsp_y", w2y, 2'b10);
    checkOutput("w2_rsp_id", w2id, 0);
    @(negedge clk);
    checkOutput("w2_idle_valid", w2rv, 0);
    checkOutput("w2_idle_busy", w2busy, 0);
    @(posedge clk);
    #1;

    drain();
    checkOutput("queue_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
